pe_ram_load_sequencer: RTL and testbench

- Sequences filter-weight loading into the per-PE filter caches (pe_ram instances) across the PE array.
- Accepts a valid/ready stream of RAM-width filter words and emits one ram_write_request_t per accepted word, stepping address, then filter_id, then pe_id.
- Sits between the DDR/stream filter reader and the broadcast write-request bus shared by all pe_ram instances.

---
 rtl/pe_ram_load_sequencer_pkg.sv | 24 ++
 rtl/pe_ram_load_counter.sv | 60 ++++++
 rtl/pe_ram_load_sequencer.sv | 124 ++++++++++++
 tb/tb_pe_ram_load_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ram_load_sequencer_pkg.sv
// Shared types and configuration for the PE filter-cache load sequencer.
// Optional abort support is enabled by defining PE_RAM_LOAD_SEQ_ABORT_EN.
package pe_ram_load_sequencer_pkg;

    localparam int unsigned NUM_FILTERS    = 2;
    localparam int unsigned RAM_DEPTH      = 512;
    localparam int unsigned RAM_ADDR_WIDTH = 9;
    localparam int unsigned RAM_WIDTH      = 16;

    typedef logic [RAM_ADDR_WIDTH-1:0] ram_addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_seq_state_e;

    function automatic int unsigned pe_id_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned FILTER_ID_WIDTH = pe_id_width(NUM_FILTERS);

endpackage

// File: rtl/pe_ram_load_counter.sv
// Nested word -> filter -> pe counter with per-level wrap flags.
// Optional abort support (PE_RAM_LOAD_SEQ_ABORT_EN) does not affect this block.
module pe_ram_load_counter
    import pe_ram_load_sequencer_pkg::*;
#(
    parameter int unsigned NUM_PES = 4,
    localparam int unsigned PE_W   = pe_id_width(NUM_PES)
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        i_clear,
    input  logic                        i_step,
    input  logic [RAM_ADDR_WIDTH:0]     i_count,
    output logic [RAM_ADDR_WIDTH-1:0]   o_word,
    output logic [FILTER_ID_WIDTH-1:0]  o_filter,
    output logic [PE_W-1:0]             o_pe,
    output logic                        o_word_wrap,
    output logic                        o_filter_wrap,
    output logic                        o_pe_wrap
);

    localparam logic [FILTER_ID_WIDTH-1:0] FILT_LAST = FILTER_ID_WIDTH'(NUM_FILTERS - 1);
    localparam logic [PE_W-1:0]            PE_LAST   = PE_W'(NUM_PES - 1);

    logic [RAM_ADDR_WIDTH-1:0]  r_word;
    logic [FILTER_ID_WIDTH-1:0] r_filter;
    logic [PE_W-1:0]            r_pe;

    assign o_word        = r_word;
    assign o_filter      = r_filter;
    assign o_pe          = r_pe;
    assign o_word_wrap   = ({1'b0, r_word} == (i_count - (RAM_ADDR_WIDTH+1)'(1)));
    assign o_filter_wrap = (r_filter == FILT_LAST);
    assign o_pe_wrap     = (r_pe == PE_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_word   <= '0;
            r_filter <= '0;
            r_pe     <= '0;
        end else if (i_clear) begin
            r_word   <= '0;
            r_filter <= '0;
            r_pe     <= '0;
        end else if (i_step) begin
            if (o_word_wrap) begin
                r_word <= '0;
                if (o_filter_wrap) begin
                    r_filter <= '0;
                    r_pe     <= o_pe_wrap ? '0 : r_pe + PE_W'(1);
                end else begin
                    r_filter <= r_filter + FILTER_ID_WIDTH'(1);
                end
            end else begin
                r_word <= r_word + RAM_ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/pe_ram_load_sequencer.sv
// Streams filter words into per-PE caches as registered write requests.
// Define PE_RAM_LOAD_SEQ_ABORT_EN to add i_abort / o_aborted.
module pe_ram_load_sequencer
    import pe_ram_load_sequencer_pkg::*;
#(
    parameter int unsigned NUM_PES = 4,
    localparam int unsigned PE_W   = pe_id_width(NUM_PES),
    localparam int unsigned REQ_W  = 1 + PE_W + FILTER_ID_WIDTH + RAM_ADDR_WIDTH + RAM_WIDTH
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      i_start,
    input  logic [RAM_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [RAM_ADDR_WIDTH:0]   i_num_words,
    input  logic [RAM_WIDTH-1:0]      i_data,
    input  logic                      i_valid,
`ifdef PE_RAM_LOAD_SEQ_ABORT_EN
    input  logic                      i_abort,
    output logic                      o_aborted,
`endif
    output logic                      o_ready,
    output logic [REQ_W-1:0]          o_write_request,
    output logic                      o_busy,
    output logic                      o_done
);

    typedef struct packed {
        logic                       enable;
        logic [PE_W-1:0]            pe_id;
        logic [FILTER_ID_WIDTH-1:0] filter_id;
        ram_addr_t                  addr;
        logic [RAM_WIDTH-1:0]       data;
    } ram_write_request_t;

    localparam logic [RAM_ADDR_WIDTH:0] DEPTH_W = (RAM_ADDR_WIDTH+1)'(RAM_DEPTH);

    load_seq_state_e            r_state, w_state_next;
    ram_addr_t                  r_base;
    logic [RAM_ADDR_WIDTH:0]    r_count;
    ram_write_request_t         r_req;

    logic                       w_start_ok, w_abort, w_hs, w_last;
    logic [RAM_ADDR_WIDTH:0]    w_num_clamped, w_addr_sum, w_addr_mod;
    logic [RAM_ADDR_WIDTH-1:0]  w_word;
    logic [FILTER_ID_WIDTH-1:0] w_filter;
    logic [PE_W-1:0]            w_pe;
    logic                       w_word_wrap, w_filter_wrap, w_pe_wrap;

`ifdef PE_RAM_LOAD_SEQ_ABORT_EN
    logic r_aborted;
    assign w_abort   = (r_state == LOAD) && i_abort;
    assign o_aborted = r_aborted && (r_state == DONE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)         r_aborted <= 1'b0;
        else if (w_start_ok) r_aborted <= 1'b0;
        else if (w_abort)    r_aborted <= 1'b1;
    end
`else
    assign w_abort = 1'b0;
`endif

    // o_ready depends on registered state only, so i_valid never reaches it.
    assign o_ready         = (r_state == LOAD);
    assign o_busy          = (r_state != IDLE);
    assign o_done          = (r_state == DONE);
    assign o_write_request = r_req;

    assign w_start_ok    = (r_state == IDLE) && i_start;
    assign w_hs          = i_valid && o_ready && !w_abort;
    assign w_last        = w_word_wrap && w_filter_wrap && w_pe_wrap;
    assign w_num_clamped = (i_num_words > DEPTH_W) ? DEPTH_W : i_num_words;
    assign w_addr_sum    = {1'b0, r_base} + {1'b0, w_word};
    assign w_addr_mod    = (w_addr_sum >= DEPTH_W) ? (w_addr_sum - DEPTH_W) : w_addr_sum;

    pe_ram_load_counter #(
        .NUM_PES (NUM_PES)
    ) u_counter (
        .clock         (clock),
        .resetn        (resetn),
        .i_clear       (w_start_ok),
        .i_step        (w_hs),
        .i_count       (r_count),
        .o_word        (w_word),
        .o_filter      (w_filter),
        .o_pe          (w_pe),
        .o_word_wrap   (w_word_wrap),
        .o_filter_wrap (w_filter_wrap),
        .o_pe_wrap     (w_pe_wrap)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (i_start) w_state_next = (i_num_words == '0) ? DONE : LOAD;
            LOAD: if (w_abort || (w_hs && w_last)) w_state_next = DONE;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_count <= '0;
            r_req   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_req.enable <= w_hs;
            if (w_start_ok) begin
                r_base  <= i_base_addr;
                r_count <= w_num_clamped;
            end
            if (w_hs) begin
                r_req.pe_id     <= w_pe;
                r_req.filter_id <= w_filter;
                r_req.addr      <= w_addr_mod[RAM_ADDR_WIDTH-1:0];
                r_req.data      <= i_data;
            end
        end
    end

endmodule

// File: tb/tb_pe_ram_load_sequencer.sv
// Directed bench for pe_ram_load_sequencer with NUM_PES=2, NUM_FILTERS=2, RAM_DEPTH=512.
// Abort scenario is exercised when PE_RAM_LOAD_SEQ_ABORT_EN is defined.
module tb_pe_ram_load_sequencer;

    // request layout: {enable[27], pe_id[26], filter_id[25], addr[24:16], data[15:0]}
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        i_start = 1'b0;
    logic [8:0]  i_base_addr = '0;
    logic [9:0]  i_num_words = '0;
    logic [15:0] i_data = '0;
    logic        i_valid = 1'b0;
    logic        o_ready, o_busy, o_done;
    logic [27:0] req;
`ifdef PE_RAM_LOAD_SEQ_ABORT_EN
    logic        i_abort = 1'b0;
    logic        o_aborted;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pe_ram_load_sequencer #(
        .NUM_PES (2)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .i_start         (i_start),
        .i_base_addr     (i_base_addr),
        .i_num_words     (i_num_words),
        .i_data          (i_data),
        .i_valid         (i_valid),
`ifdef PE_RAM_LOAD_SEQ_ABORT_EN
        .i_abort         (i_abort),
        .o_aborted       (o_aborted),
`endif
        .o_ready         (o_ready),
        .o_write_request (req),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_load(input logic [8:0] base, input logic [9:0] n);
        i_base_addr = base;
        i_num_words = n;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if (req !== 28'h0 || o_ready !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL reset: req=%h ready=%b busy=%b done=%b, want all zero", req, o_ready, o_busy, o_done);
        end
        #3 resetn = 1'b1;
        tick();
    endtask

    task automatic test_full_load();
        logic [27:0] exp;
        start_load(9'd0, 10'd3);
        checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL load_entry: ready=%b busy=%b, want 1 1", o_ready, o_busy);
        end
        for (int k = 0; k < 12; k++) begin
            i_valid = 1'b1;
            i_data  = 16'hA000 + 16'(k);
            tick();
            exp = {1'b1, 1'(k / 6), 1'((k / 3) % 2), 9'(k % 3), 16'hA000 + 16'(k)};
            checks++;
            if (req !== exp) begin
                errors++;
                $display("FAIL full_req k=%0d: got=%h want=%h", k, req, exp);
            end
            checks++;
            if (o_done !== (k == 11)) begin
                errors++;
                $display("FAIL full_done k=%0d: got=%b want=%b", k, o_done, (k == 11));
            end
        end
        i_valid = 1'b0;
        tick();
        checks++;
        if (req[27] !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_idle: en=%b done=%b busy=%b ready=%b, want 0 0 0 0", req[27], o_done, o_busy, o_ready);
        end
    endtask

    task automatic test_addr_wrap();
        logic [27:0] exp;
        start_load(9'd510, 10'd4);
        for (int k = 0; k < 16; k++) begin
            i_valid = 1'b1;
            i_data  = 16'(k);
            tick();
            exp = {1'b1, 1'(k / 8), 1'((k / 4) % 2), 9'((510 + (k % 4)) % 512), 16'(k)};
            checks++;
            if (req !== exp) begin
                errors++;
                $display("FAIL wrap_req k=%0d: got=%h want=%h", k, req, exp);
            end
        end
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done: got=%b want=1", o_done);
        end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        logic [27:0] exp;
        logic        v;
        int          w = 0;
        logic        seen_done = 1'b0;
        start_load(9'd5, 10'd2);
        for (int c = 0; c < 64 && !seen_done; c++) begin
            v       = ((c % 4) == 0) || ((c % 4) == 3);
            i_valid = v;
            i_data  = 16'h5000 + 16'(c);
            tick();
            checks++;
            if (req[27] !== v) begin
                errors++;
                $display("FAIL stall_en c=%0d: got=%b want=%b", c, req[27], v);
            end
            if (v) begin
                exp = {1'b1, 1'(w / 4), 1'((w / 2) % 2), 9'(5 + (w % 2)), 16'h5000 + 16'(c)};
                w++;
                checks++;
                if (req !== exp) begin
                    errors++;
                    $display("FAIL stall_req c=%0d: got=%h want=%h", c, req, exp);
                end
            end
            checks++;
            if (o_done !== (w == 8)) begin
                errors++;
                $display("FAIL stall_done c=%0d: got=%b want=%b", c, o_done, (w == 8));
            end
            seen_done = o_done;
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL stall_timeout: done=0 after 64 cycles, want done");
        end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_zero_words();
        start_load(9'd3, 10'd0);
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b1 || o_ready !== 1'b0 || req[27] !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b ready=%b en=%b, want 1 1 0 0", o_done, o_busy, o_ready, req[27]);
        end
        tick();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || req[27] !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: done=%b busy=%b en=%b, want 0 0 0", o_done, o_busy, req[27]);
        end
    endtask

    task automatic test_start_ignored();
        logic [27:0] exp;
        int          w = 0;
        logic        seen_done = 1'b0;
        start_load(9'd7, 10'd1);
        for (int k = 0; k < 20 && !seen_done; k++) begin
            i_valid = 1'b1;
            i_data  = 16'h7700 + 16'(k);
            if (k == 1) begin
                i_start     = 1'b1;
                i_base_addr = 9'd100;
                i_num_words = 10'd3;
            end
            tick();
            i_start = 1'b0;
            if (req[27] === 1'b1) begin
                exp = {1'b1, 1'(w / 2), 1'(w % 2), 9'd7, 16'h7700 + 16'(k)};
                w++;
                checks++;
                if (req !== exp) begin
                    errors++;
                    $display("FAIL restart_req k=%0d: got=%h want=%h", k, req, exp);
                end
            end
            seen_done = o_done;
        end
        checks++;
        if (w !== 4 || !seen_done) begin
            errors++;
            $display("FAIL restart_count: writes=%0d done=%b, want 4 1", w, seen_done);
        end
        i_valid = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: busy=%b ready=%b, want 0 0", o_busy, o_ready);
        end
    endtask

    task automatic test_clamp();
        int   w = 0;
        int   bad = 0;
        int   done_at = -1;
        start_load(9'd0, 10'd600);
        for (int c = 0; c < 2100 && done_at < 0; c++) begin
            i_valid = 1'b1;
            i_data  = 16'(c);
            tick();
            if (req[27] === 1'b1) begin
                if (req[24:16] !== 9'(w % 512)) bad++;
                w++;
            end
            if (o_done === 1'b1) done_at = w;
        end
        i_valid = 1'b0;
        checks++;
        if (w !== 2048 || done_at !== 2048 || bad !== 0) begin
            errors++;
            $display("FAIL clamp: writes=%0d done_at=%0d bad_addr=%0d, want 2048 2048 0", w, done_at, bad);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [27:0] exp;
        start_load(9'd20, 10'd3);
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_data  = 16'(k);
            tick();
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (req[27] !== 1'b0 || o_ready !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: en=%b ready=%b busy=%b, want 0 0 0", req[27], o_ready, o_busy);
        end
        #2 resetn = 1'b1;
        i_valid = 1'b0;
        tick();
        start_load(9'd20, 10'd3);
        i_valid = 1'b1;
        i_data  = 16'h0055;
        tick();
        exp = {1'b1, 1'b0, 1'b0, 9'd20, 16'h0055};
        checks++;
        if (req !== exp) begin
            errors++;
            $display("FAIL restart_first: got=%h want=%h", req, exp);
        end
        i_data = 16'h0056;
        tick();
        exp = {1'b1, 1'b0, 1'b0, 9'd21, 16'h0056};
        checks++;
        if (req !== exp) begin
            errors++;
            $display("FAIL restart_second: got=%h want=%h", req, exp);
        end
        i_valid = 1'b0;
        #2 resetn = 1'b0;
        #2 resetn = 1'b1;
        tick();
    endtask

`ifdef PE_RAM_LOAD_SEQ_ABORT_EN
    task automatic test_abort();
        int w = 0;
        start_load(9'd0, 10'd3);
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1;
            i_data  = 16'(k);
            i_abort = (k == 2);
            tick();
            if (req[27] === 1'b1) w++;
        end
        i_abort = 1'b0;
        i_valid = 1'b0;
        checks++;
        if (w !== 2 || req[27] !== 1'b0 || o_done !== 1'b1 || o_aborted !== 1'b1) begin
            errors++;
            $display("FAIL abort: writes=%0d en=%b done=%b aborted=%b, want 2 0 1 1", w, req[27], o_done, o_aborted);
        end
        tick();
        checks++;
        if (o_done !== 1'b0 || o_aborted !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: done=%b aborted=%b busy=%b, want 0 0 0", o_done, o_aborted, o_busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_addr_wrap();
        test_stall();
        test_zero_words();
        test_start_ignored();
        test_clamp();
        test_reset_mid();
`ifdef PE_RAM_LOAD_SEQ_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
